// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, LSB-first byte assembly, FCS strip.
// Define RX_DEFRAMER_CRC_CHECK_EN to compile the CRC-16/CCITT FCS check.
module rx_deframer #(
  parameter int MIN_BYTES = 3
) (
  input  logic       netclk,
  input  logic       reset,
  input  logic       rxdata,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_end,
  output logic       frame_good,
  output logic       frame_error,
  output logic       abort
);
  typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_t;

  state_t          state, state_b;
  logic [7:0]      w, nw, sh, sh_b;
  logic [3:0]      fill, nfill;
  logic [2:0]      ones, dcnt, bitcnt, bitcnt_b;
  logic [15:0]     bytecnt, bytecnt_b;
  logic [1:0][7:0] hb;
  logic [1:0]      hcnt;
  logic            flag, abort_hit, b, bit_v, take, byte_done;
  logic            aligned, long_enough, crc_ok;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
  logic [15:0]     crc, crc_b;
  logic            fb;
`endif

  // *_b values are the state after this edge's destuffed bit, so a flag that
  // completes on the same edge as the last FCS bit sees the whole frame.
  always_comb begin
    nw          = {rxdata, w[7:1]};
    nfill       = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
    flag        = (nfill == 4'd8) && (nw == 8'h7E);
    abort_hit   = rxdata && (ones == 3'd6);
    b           = w[0];
    bit_v       = (fill == 4'd8) && (state != HUNT) && !abort_hit;
    take        = bit_v && !(!b && (dcnt == 3'd5));
    sh_b        = take ? {b, sh[7:1]} : sh;
    bitcnt_b    = take ? bitcnt + 3'd1 : bitcnt;
    byte_done   = take && (bitcnt == 3'd7);
    bytecnt_b   = (byte_done && (bytecnt != 16'hFFFF)) ? bytecnt + 16'd1 : bytecnt;
    state_b     = (state == SYNC && take) ? FRAME : state;
    aligned     = (bitcnt_b == 3'd0);
    long_enough = (bytecnt_b >= 16'(MIN_BYTES));
`ifdef RX_DEFRAMER_CRC_CHECK_EN
    fb          = b ^ crc[15];
    crc_b       = take ? ({crc[14:0], 1'b0} ^ ({16{fb}} & 16'h1021)) : crc;
    crc_ok      = (crc_b == 16'h1D0F);
`else
    crc_ok      = 1'b1;
`endif
  end

  always_ff @(posedge netclk) begin
    if (reset) begin
      state       <= HUNT;
      w           <= '0;
      fill        <= '0;
      ones        <= '0;
      dcnt        <= '0;
      sh          <= '0;
      bitcnt      <= '0;
      bytecnt     <= '0;
      hb          <= '0;
      hcnt        <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_end   <= 1'b0;
      frame_good  <= 1'b0;
      frame_error <= 1'b0;
      abort       <= 1'b0;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
      crc         <= 16'hFFFF;
`endif
    end else begin
      data_valid  <= 1'b0;
      frame_end   <= 1'b0;
      frame_good  <= 1'b0;
      frame_error <= 1'b0;
      abort       <= 1'b0;
      w           <= nw;
      fill        <= nfill;
      ones        <= rxdata ? ((ones == 3'd7) ? 3'd7 : ones + 3'd1) : 3'd0;
      if (bit_v) dcnt <= b ? ((dcnt == 3'd7) ? 3'd7 : dcnt + 3'd1) : 3'd0;
      if (take) begin
        sh      <= sh_b;
        bitcnt  <= bitcnt_b;
        bytecnt <= bytecnt_b;
        state   <= state_b;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
        crc     <= crc_b;
`endif
      end
      // two-byte holdback keeps the FCS from ever reaching data_out
      if (byte_done) begin
        if (hcnt == 2'd2) begin
          data_out   <= hb[0];
          data_valid <= 1'b1;
          hb[0]      <= hb[1];
          hb[1]      <= sh_b;
        end else begin
          hb[hcnt[0]] <= sh_b;
          hcnt        <= hcnt + 2'd1;
        end
      end
      if (abort_hit) begin
        fill  <= '0;
        hcnt  <= '0;
        dcnt  <= '0;
        state <= HUNT;
        abort <= (state == FRAME);
      end else if (flag) begin
        fill    <= '0;
        hcnt    <= '0;
        dcnt    <= '0;
        bitcnt  <= '0;
        bytecnt <= '0;
        state   <= SYNC;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
        crc     <= 16'hFFFF;
`endif
        if (state_b == FRAME) begin
          frame_end   <= 1'b1;
          frame_good  <= aligned && long_enough && crc_ok;
          frame_error <= !(aligned && long_enough && crc_ok);
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: frame table, corner sequences, random frames.
module tb_rx_deframer;
`ifdef RX_DEFRAMER_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam int MIN_BYTES = 3;

  logic       netclk = 1'b0, reset = 1'b1, rxdata = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_end, frame_good, frame_error, abort;

  rx_deframer #(.MIN_BYTES(MIN_BYTES)) dut (
    .netclk(netclk), .reset(reset), .rxdata(rxdata), .data_out(data_out),
    .data_valid(data_valid), .frame_end(frame_end), .frame_good(frame_good),
    .frame_error(frame_error), .abort(abort));

  always #5 netclk = ~netclk;

  typedef bit bitq_t[$];
  typedef struct {
    int              n;      // payload bytes
    logic [5:0][7:0] b;
    bit              fcs;    // append FCS
    bit              flip;   // corrupt one FCS bit
    int              xn;     // extra raw bits after content
    logic [31:0]     xv;
    int              nout;   // expected data_valid count
    bit              good;   // expected frame_good
  } vec_t;

  int checks = 0, errors = 0, n_abort = 0;
  logic [7:0] got_q[$];
  logic [1:0] end_q[$];

  always @(negedge netclk) if (!reset) begin
    if (data_valid) got_q.push_back(data_out);
    if (frame_end) end_q.push_back({frame_good, frame_error});
    if (abort) n_abort++;
    if (!frame_end && (frame_good || frame_error)) begin
      errors++;
      $display("FAIL status_without_end: good=%0b error=%0b required 0,0", frame_good, frame_error);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic send_bit(input bit v);
    @(posedge netclk); #1 rxdata = v;
  endtask

  task automatic send_flag();
    logic [7:0] f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
  endtask

  task automatic send_stuffed(input bitq_t bits);
    int run = 0;
    foreach (bits[i]) begin
      send_bit(bits[i]);
      run = bits[i] ? run + 1 : 0;
      if (run == 5) begin send_bit(1'b0); run = 0; end
    end
  endtask

  function automatic logic [15:0] crc_of(input bitq_t bits);
    logic [15:0] c = 16'hFFFF;
    foreach (bits[i]) c = {c[14:0], 1'b0} ^ ((bits[i] ^ c[15]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  function automatic bitq_t build(input vec_t v);
    bitq_t q;
    logic [15:0] f;
    for (int k = 0; k < v.n; k++) for (int i = 0; i < 8; i++) q.push_back(v.b[k][i]);
    if (v.fcs) begin
      f = ~crc_of(q);
      if (v.flip) f[5] = ~f[5];
      for (int i = 15; i >= 0; i--) q.push_back(f[i]);
    end
    for (int i = 0; i < v.xn; i++) q.push_back(v.xv[i]);
    return q;
  endfunction

  task automatic clear();
    got_q.delete(); end_q.delete(); n_abort = 0;
  endtask

  // frame-level expectation: all but the last two whole bytes come out
  task automatic run_frame(input string nm, input vec_t v, input logic [7:0] exp_b[$], input bit good);
    bitq_t bits = build(v);
    clear();
    send_flag(); send_stuffed(bits); send_flag(); send_flag(); send_flag();
    chk({nm, "_nbytes"}, got_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), got_q[i], exp_b[i]);
    chk({nm, "_nend"}, end_q.size(), 1);
    if (end_q.size() > 0) chk({nm, "_status"}, end_q[0], good ? 2 : 1);
    chk({nm, "_abort"}, n_abort, 0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_data_out"}, data_out, 0);
    chk({nm, "_data_valid"}, data_valid, 0);
    chk({nm, "_frame_end"}, frame_end, 0);
    chk({nm, "_frame_good"}, frame_good, 0);
    chk({nm, "_frame_error"}, frame_error, 0);
    chk({nm, "_abort"}, abort, 0);
  endtask

  vec_t tbl[9];
  vec_t v;
  logic [7:0] eb[$];

  initial begin
    tbl[0] = '{1, {40'h0, 8'h41}, 1, 0, 0, 0, 1, 1};
    tbl[1] = '{3, {24'h0, 8'h7E, 8'h3E, 8'hFF}, 1, 0, 0, 0, 3, 1};
    tbl[2] = '{3, {24'h0, 8'h7E, 8'h3E, 8'hFF}, 1, 1, 0, 0, 3, !CRC_EN};
    tbl[3] = '{2, {32'h0, 8'h34, 8'h12}, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 48'h0, 0, 0, 20, 32'h000A5A5A, 0, 0};
    tbl[5] = '{0, 48'h0, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{4, {16'h0, 8'h00, 8'hF8, 8'h1F, 8'h00}, 1, 0, 0, 0, 4, 1};
    tbl[7] = '{2, {32'h0, 8'hC3, 8'h5A}, 1, 0, 3, 32'h5, 2, 0};
    tbl[8] = '{6, {8'hFF, 8'hFF, 8'h7D, 8'h7E, 8'hFF, 8'hFE}, 1, 0, 0, 0, 6, 1};

    repeat (3) @(posedge netclk);
    @(negedge netclk);
    chk_outputs_zero("reset");
    @(posedge netclk); #1 reset = 1'b0;

    clear();
    repeat (12) send_bit(1'b1);
    repeat (4) send_flag();
    chk("idle_dv", got_q.size(), 0);
    chk("idle_end", end_q.size(), 0);
    chk("idle_abort", n_abort, 0);

    for (int t = 0; t < 9; t++) begin
      eb.delete();
      for (int i = 0; i < tbl[t].nout; i++) eb.push_back(tbl[t].b[i]);
      run_frame($sformatf("tbl%0d", t), tbl[t], eb, tbl[t].good);
    end

    // abort after two payload bytes, then a clean frame
    clear();
    send_flag();
    v = '{2, {32'h0, 8'h42, 8'h41}, 0, 0, 0, 0, 0, 0};
    send_stuffed(build(v));
    repeat (11) send_bit(1'b1);
    send_flag(); send_flag();
    chk("abort_pulses", n_abort, 1);
    chk("abort_end", end_q.size(), 0);
    chk("abort_dv", got_q.size(), 0);
    eb.delete(); eb.push_back(8'h41);
    run_frame("after_abort", tbl[0], eb, 1'b1);

    // one-cycle reset in the middle of a frame
    clear();
    send_flag();
    v = '{3, {24'h0, 8'h33, 8'h22, 8'h11}, 0, 0, 0, 0, 0, 0};
    send_stuffed(build(v));
    @(posedge netclk); #1 reset = 1'b1;
    @(posedge netclk); #1 reset = 1'b0;
    @(negedge netclk);
    chk_outputs_zero("midreset");
    send_flag(); send_flag();
    chk("midreset_end", end_q.size(), 0);
    chk("midreset_abort", n_abort, 0);
    eb.delete(); eb.push_back(8'h41);
    run_frame("after_reset", tbl[0], eb, 1'b1);

    // random frames against the frame-level model
    for (int r = 0; r < 25; r++) begin
      bitq_t bits;
      int nb;
      bit good;
      v.n    = $urandom_range(0, 6);
      v.b    = {$urandom, $urandom};
      v.fcs  = ($urandom_range(0, 5) != 0);
      v.flip = ($urandom_range(0, 3) == 0);
      v.xn   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0;
      v.xv   = $urandom;
      bits   = build(v);
      nb     = bits.size() / 8;
      eb.delete();
      for (int k = 0; k < nb - 2; k++) begin
        logic [7:0] by;
        for (int i = 0; i < 8; i++) by[i] = bits[8*k + i];
        eb.push_back(by);
      end
      good = (bits.size() % 8 == 0) && (nb >= MIN_BYTES) &&
             (!CRC_EN || (v.fcs && !v.flip && v.xn == 0));
      if (bits.size() > 0) run_frame($sformatf("rnd%0d", r), v, eb, good);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
